// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common-data-bus arbiter.
// Optional statistics counters are enabled with the CDB_STATS_EN macro.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ = 3;   // producers: ALU RS, LSB, branch unit
  localparam int CDB_ROB_W   = 4;   // ROB tag width
  localparam int CDB_DATA_W  = 32;  // result width
  localparam int CDB_CNT_W   = 16;  // statistics counter width

  // Fixed producer slots on the bus.
  typedef enum logic [1:0] {
    CDB_SRC_ALU = 2'd0,
    CDB_SRC_LSB = 2'd1,
    CDB_SRC_BR  = 2'd2
  } cdb_src_e;

  // Round-robin successor of idx among n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer handshake and CDB broadcast bundle.
// master = producers/environment side, slave = the arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int ROB_W   = CDB_ROB_W,
  parameter int DATA_W  = CDB_DATA_W
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic                      rdy_in;
  logic                      flush_in;
  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ*ROB_W-1:0]  req_rob_id_in;
  logic [NUM_REQ*DATA_W-1:0] req_data_in;
  logic [NUM_REQ-1:0]        req_ready_out;
  logic                      cdb_valid_out;
  logic [ROB_W-1:0]          cdb_rob_id_out;
  logic [DATA_W-1:0]         cdb_data_out;
  logic [SRC_W-1:0]          cdb_src_out;

  modport master (
    output rdy_in, flush_in, req_valid_in, req_rob_id_in, req_data_in,
    input  req_ready_out, cdb_valid_out, cdb_rob_id_out, cdb_data_out, cdb_src_out
  );

  modport slave (
    input  rdy_in, flush_in, req_valid_in, req_rob_id_in, req_data_in,
    output req_ready_out, cdb_valid_out, cdb_rob_id_out, cdb_data_out, cdb_src_out
  );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. Reusable for the RS issue pickers.
module cdb_arbiter_rr_picker #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan N slots starting at ptr; the first valid one wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a value unassigned (no latch).
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = 0; off < N; off++) begin
      int j;
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant among producers, one registered broadcast
// per cycle, flush kills the next broadcast, rdy_in low freezes all state.
// Define CDB_STATS_EN to add per-producer grant and conflict counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int ROB_W   = CDB_ROB_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic clk_in,
  input  logic rst_in,
  cdb_arbiter_if.slave bus
`ifdef CDB_STATS_EN
  ,
  output logic [NUM_REQ*CDB_CNT_W-1:0] stat_grant_cnt_out,
  output logic [CDB_CNT_W-1:0]         stat_conflict_cnt_out
`endif
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic [SRC_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_any;
  logic               fire;
  logic [ROB_W-1:0]   sel_rob_id;
  logic [DATA_W-1:0]  sel_data;

  cdb_arbiter_rr_picker #(.N(NUM_REQ), .IW(SRC_W)) u_picker (
    .req   (bus.req_valid_in),
    .ptr   (rr_ptr),
    .grant (grant_onehot),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // A handshake happens only out of reset, not stalled, not flushing.
  assign fire              = rst_in & bus.rdy_in & ~bus.flush_in & grant_any;
  assign bus.req_ready_out = fire ? grant_onehot : '0;
  assign sel_rob_id        = bus.req_rob_id_in[grant_idx*ROB_W +: ROB_W];
  assign sel_data          = bus.req_data_in[grant_idx*DATA_W +: DATA_W];

  // Broadcast register and round-robin pointer.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus.cdb_valid_out  <= 1'b0;
      bus.cdb_rob_id_out <= '0;
      bus.cdb_data_out   <= '0;
      bus.cdb_src_out    <= '0;
      rr_ptr             <= '0;
    end else if (bus.rdy_in) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (fire) begin
        bus.cdb_valid_out  <= 1'b1;
        bus.cdb_rob_id_out <= sel_rob_id;
        bus.cdb_data_out   <= sel_data;
        bus.cdb_src_out    <= grant_idx;
        rr_ptr             <= SRC_W'(rr_next(int'(grant_idx), NUM_REQ));
      end else begin
        // No grant or flush: drop valid, keep tag/data/src and pointer.
        bus.cdb_valid_out <= 1'b0;
      end
    end
  end

`ifdef CDB_STATS_EN
  logic [CDB_CNT_W-1:0] grant_cnt [NUM_REQ];
  logic [CDB_CNT_W-1:0] conflict_cnt;
  logic                 conflict;

  assign conflict = ($countones(bus.req_valid_in) >= 2);

  // Saturating grant and conflict counters; frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      // NOTE: this small counter array is register-based, so it is reset explicitly element by element.
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      conflict_cnt <= '0;
    end else if (bus.rdy_in) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire && grant_onehot[i] && (grant_cnt[i] != '1))
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
      if (conflict && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  // Flatten the per-producer counters onto the packed stats port.
  always_comb begin
    stat_grant_cnt_out = '0;
    for (int i = 0; i < NUM_REQ; i++)
      stat_grant_cnt_out[i*CDB_CNT_W +: CDB_CNT_W] = grant_cnt[i];
  end

  assign stat_conflict_cnt_out = conflict_cnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter. The driver issues one cycle of stimulus at
// each falling edge, checks the combinational grant and pushes the expected
// broadcast into a scoreboard; a monitor pops it after each rising edge.
// Statistics checks are compiled in when CDB_STATS_EN is defined.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int RW = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [RW-1:0] rob;
    logic [DW-1:0] data;
    logic [1:0]    src;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  logic [RW-1:0] tag_tbl  [NR];
  logic [DW-1:0] data_tbl [NR];

  cdb_arbiter_if #(.NUM_REQ(NR), .ROB_W(RW), .DATA_W(DW)) bus ();

`ifdef CDB_STATS_EN
  logic [NR*16-1:0] stat_grant_cnt_out;
  logic [15:0]      stat_conflict_cnt_out;
`endif

  cdb_arbiter #(.NUM_REQ(NR), .ROB_W(RW), .DATA_W(DW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
`ifdef CDB_STATS_EN
    ,
    .stat_grant_cnt_out    (stat_grant_cnt_out),
    .stat_conflict_cnt_out (stat_conflict_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One stimulus cycle: drive at the falling edge, check the grant, and
  // queue the broadcast that the expected grant should produce.
  task automatic drive(input logic [NR-1:0] v, input logic fl, input logic rd,
                       input logic [NR-1:0] exp_ready, input string name);
    @(negedge clk_in);
    bus.req_valid_in = v;
    bus.flush_in     = fl;
    bus.rdy_in       = rd;
    #1;
    check(name, 64'(bus.req_ready_out), 64'(exp_ready));
    for (int i = 0; i < NR; i++) begin
      if (exp_ready[i]) sb_q.push_back('{rob: tag_tbl[i], data: data_tbl[i], src: 2'(i)});
    end
  endtask

  task automatic check_bcast(input string name, input logic v, input logic [1:0] src);
    check({name, "_valid"}, 64'(bus.cdb_valid_out), 64'(v));
    check({name, "_src"},   64'(bus.cdb_src_out),   64'(src));
  endtask

  // Monitor: after each rising edge that updated the register, compare.
  initial begin
    logic rdy_at_edge;
    logic rst_at_edge;
    exp_t e;
    forever begin
      @(posedge clk_in);
      rdy_at_edge = bus.rdy_in;
      rst_at_edge = rst_in;
      #1;
      if (rst_at_edge && rst_in && rdy_at_edge && bus.cdb_valid_out) begin
        if (sb_q.size() == 0) begin
          check("mon_unexpected_bcast", 64'(bus.cdb_valid_out), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("mon_rob",  64'(bus.cdb_rob_id_out), 64'(e.rob));
          check("mon_data", 64'(bus.cdb_data_out),   64'(e.data));
          check("mon_src",  64'(bus.cdb_src_out),    64'(e.src));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tag_tbl[0] = 4'd3;  data_tbl[0] = 32'hA0A0_0001;
    tag_tbl[1] = 4'd5;  data_tbl[1] = 32'h0000_1234;
    tag_tbl[2] = 4'd11; data_tbl[2] = 32'hCAFE_0002;
    bus.req_rob_id_in = {tag_tbl[2], tag_tbl[1], tag_tbl[0]};
    bus.req_data_in   = {data_tbl[2], data_tbl[1], data_tbl[0]};
    bus.req_valid_in  = 3'b111;
    bus.rdy_in        = 1'b1;
    bus.flush_in      = 1'b0;

    // Reset state, with requests present: no grant, outputs cleared.
    rst_in = 1'b1;
    #2 rst_in = 1'b0;
    #1;
    check("rst_ready", 64'(bus.req_ready_out),  64'(0));
    check("rst_valid", 64'(bus.cdb_valid_out),  64'(0));
    check("rst_rob",   64'(bus.cdb_rob_id_out), 64'(0));
    check("rst_data",  64'(bus.cdb_data_out),   64'(0));
    check("rst_src",   64'(bus.cdb_src_out),    64'(0));
    @(negedge clk_in);
    bus.req_valid_in = '0;
    rst_in = 1'b1;

    // 1: single request from producer 1 (p: 0 -> 2).
    drive(3'b010, 1'b0, 1'b1, 3'b010, "t1_grant");
    drive(3'b000, 1'b0, 1'b1, 3'b000, "t1_idle");
    check_bcast("t1_bcast", 1'b1, CDB_SRC_LSB);
    drive(3'b000, 1'b0, 1'b1, 3'b000, "t1_idle2");
    check_bcast("t1_after", 1'b0, CDB_SRC_LSB);

    // 2: move p to 0 via producer 2, then all valid rotate 0,1,2,0,1,2.
    drive(3'b100, 1'b0, 1'b1, 3'b100, "t2_pre");
    drive(3'b111, 1'b0, 1'b1, 3'b001, "t2_g0");
    drive(3'b111, 1'b0, 1'b1, 3'b010, "t2_g1");
    drive(3'b111, 1'b0, 1'b1, 3'b100, "t2_g2");
    drive(3'b111, 1'b0, 1'b1, 3'b001, "t2_g3");
    drive(3'b111, 1'b0, 1'b1, 3'b010, "t2_g4");
    drive(3'b111, 1'b0, 1'b1, 3'b100, "t2_g5");

    // 3: flush with producer 0 waiting: no grant, valid drops, then grant 0.
    drive(3'b001, 1'b1, 1'b1, 3'b000, "t3_flush");
    drive(3'b001, 1'b0, 1'b1, 3'b001, "t3_regrant");
    check("t3_killed", 64'(bus.cdb_valid_out), 64'(0));

    // 4: grant 2 (p=1 -> 0), stall 3 cycles (last one with flush), resume at 0.
    drive(3'b100, 1'b0, 1'b1, 3'b100, "t4_grant");
    drive(3'b011, 1'b0, 1'b0, 3'b000, "t4_stall1");
    check_bcast("t4_hold1", 1'b1, CDB_SRC_BR);
    drive(3'b011, 1'b0, 1'b0, 3'b000, "t4_stall2");
    check_bcast("t4_hold2", 1'b1, CDB_SRC_BR);
    drive(3'b011, 1'b1, 1'b0, 3'b000, "t4_stall_flush");
    check_bcast("t4_hold3", 1'b1, CDB_SRC_BR);
    check("t4_hold_rob", 64'(bus.cdb_rob_id_out), 64'(tag_tbl[2]));
    drive(3'b011, 1'b0, 1'b1, 3'b001, "t4_resume");
    check_bcast("t4_hold4", 1'b1, CDB_SRC_BR);
    drive(3'b011, 1'b0, 1'b1, 3'b010, "t4_next");
    drive(3'b000, 1'b0, 1'b1, 3'b000, "t4_idle");

    // 5: p=2, grant 2; next cycle grant 0 is lost to a mid-cycle async reset.
    drive(3'b111, 1'b0, 1'b1, 3'b100, "t5_grant");
    @(negedge clk_in);
    bus.req_valid_in = 3'b111;
    #1;
    check("t5_ready_pre", 64'(bus.req_ready_out), 64'(3'b001));
    #2 rst_in = 1'b0;
    #1;
    check("t5_rst_ready", 64'(bus.req_ready_out),  64'(0));
    check("t5_rst_valid", 64'(bus.cdb_valid_out),  64'(0));
    check("t5_rst_rob",   64'(bus.cdb_rob_id_out), 64'(0));
    check("t5_rst_data",  64'(bus.cdb_data_out),   64'(0));
    check("t5_rst_src",   64'(bus.cdb_src_out),    64'(0));
    @(negedge clk_in);
    bus.req_valid_in = '0;
    rst_in = 1'b1;
    drive(3'b110, 1'b0, 1'b1, 3'b010, "t5_first");
    drive(3'b000, 1'b0, 1'b1, 3'b000, "t5_idle");
    drive(3'b000, 1'b0, 1'b1, 3'b000, "t5_idle2");
    check_bcast("t5_hold", 1'b0, CDB_SRC_LSB);
    check("t5_hold_data", 64'(bus.cdb_data_out), 64'(data_tbl[1]));

`ifdef CDB_STATS_EN
    // 6: 5 conflict cycles (grants 0,1,2,0,1), then 70000 grants to 0.
    @(negedge clk_in);
    bus.req_valid_in = '0;
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    drive(3'b111, 1'b0, 1'b1, 3'b001, "t6_c0");
    drive(3'b111, 1'b0, 1'b1, 3'b010, "t6_c1");
    drive(3'b111, 1'b0, 1'b1, 3'b100, "t6_c2");
    drive(3'b111, 1'b0, 1'b1, 3'b001, "t6_c3");
    drive(3'b111, 1'b0, 1'b1, 3'b010, "t6_c4");
    for (int k = 0; k < 70000; k++) drive(3'b001, 1'b0, 1'b1, 3'b001, "t6_sat");
    drive(3'b000, 1'b0, 1'b1, 3'b000, "t6_idle");
    check("t6_cnt0",     64'(stat_grant_cnt_out[15:0]),  64'(16'hFFFF));
    check("t6_cnt1",     64'(stat_grant_cnt_out[31:16]), 64'(2));
    check("t6_cnt2",     64'(stat_grant_cnt_out[47:32]), 64'(1));
    check("t6_conflict", 64'(stat_conflict_cnt_out),     64'(5));
`endif

    drive(3'b000, 1'b0, 1'b1, 3'b000, "end_idle");
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
